// File: rtl/product_bcd_pkg.sv
// Shared types and constants for the signed-product to BCD converter.
// Holds the FSM encoding, default sizing and the double-dabble correction constants.
package product_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ABS  = 2'd1,
        CONV = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEF_WIDTH  = 16;
    // Five digits cover |-32768|.
    localparam int DEF_DIGITS = 5;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ        = 4'd3;

endpackage

// File: rtl/bcd_add3_digit.sv
// Combinational double-dabble nibble correction: values of 5 or more get 3 added.
// Zero latency, no flow control.
module bcd_add3_digit
    import product_bcd_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    always_comb begin
        dout = din;
        if (din >= BCD_ADJ_THRESH) begin
            dout = din + BCD_ADJ;
        end
    end

endmodule

// File: rtl/product_bcd_convert.sv
// Sequential signed binary to packed-BCD converter (sign + DIGITS digits) via shift-add-3.
// Latency WIDTH+2 cycles from accepted start to done; start is ignored while busy (no queueing).
module product_bcd_convert
    import product_bcd_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      product,
    output logic                  busy,
    output logic                  done,
    output logic                  sign,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CW = $clog2(WIDTH);
    localparam int BW = 4 * DIGITS;

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] prod_q,   prod_d;
    logic [WIDTH-1:0] mag_q,    mag_d;
    logic [BW-1:0]    acc_q,    acc_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic             neg_q,    neg_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic             sign_q,   sign_d;
    logic [BW-1:0]    bcd_q,    bcd_d;

    logic [BW-1:0]    acc_adj;
    logic [BW-1:0]    acc_shift;
    logic [WIDTH-1:0] mag_shift;
    logic [WIDTH-1:0] prod_abs;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_add3_digit u_adj (
            .din  (acc_q[4*i +: 4]),
            .dout (acc_adj[4*i +: 4])
        );
    end

    // One double-dabble step: correct every nibble, then shift {acc, mag} left by one.
    always_comb begin
        acc_shift = {acc_adj[BW-2:0], mag_q[WIDTH-1]};
        mag_shift = {mag_q[WIDTH-2:0], 1'b0};
    end

    // -2^(WIDTH-1) negates to itself, which reads correctly as an unsigned magnitude.
    always_comb begin
        prod_abs = prod_q;
        if (prod_q[WIDTH-1]) begin
            prod_abs = (~prod_q) + WIDTH'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        prod_d  = prod_q;
        mag_d   = mag_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sign_d  = sign_q;
        bcd_d   = bcd_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    prod_d  = product;
                    busy_d  = 1'b1;
                    state_d = ABS;
                end
            end
            ABS: begin
                neg_d   = prod_q[WIDTH-1];
                mag_d   = prod_abs;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = CONV;
            end
            CONV: begin
                acc_d = acc_shift;
                mag_d = mag_shift;
                cnt_d = cnt_q + CW'(1);
                // Results land on the edge entering DONE so done and the new value coincide.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    sign_d  = neg_q;
                    bcd_d   = acc_shift;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            prod_q  <= '0;
            mag_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sign_q  <= 1'b0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            prod_q  <= prod_d;
            mag_q   <= mag_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sign_q  <= sign_d;
            bcd_q   <= bcd_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sign = sign_q;
    assign bcd  = bcd_q;

endmodule
